// File: rtl/spi_xfer_arbiter_if.sv
// rtl/spi_xfer_arbiter_if.sv - requester handshake and SPI pin bundle for spi_xfer_arbiter
interface spi_xfer_arbiter_if #(
  parameter int W_Data = 32
);
  logic              req0;
  logic              req1;
  logic [W_Data-1:0] tx0;
  logic [W_Data-1:0] tx1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [W_Data-1:0] rx_data;
  logic              busy;
  logic              spi_clk;
  logic              spi_cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  req0, req1, tx0, tx1, miso,
    output gnt0, gnt1, done0, done1, rx_data, busy, spi_clk, spi_cs_n, mosi
  );

  modport slave (
    output req0, req1, tx0, tx1, miso,
    input  gnt0, gnt1, done0, done1, rx_data, busy, spi_clk, spi_cs_n, mosi
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin two-requester SPI mode-0 master; SPI_LOOPBACK_EN samples mosi instead of miso
module spi_xfer_arbiter #(
  parameter int W_Data     = 32,
  parameter int W_Counter  = 5,
  parameter int Gap_Cycles = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_xfer_arbiter_if.master  bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  localparam int W_Gap = (Gap_Cycles > 1) ? $clog2(Gap_Cycles) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_gnt;
  logic [W_Data-1:0]    r_tx;
  logic [W_Data-1:0]    r_rx;
  logic [W_Data-1:0]    r_rx_data;
  logic [W_Counter-1:0] r_bit;
  logic [W_Counter-1:0] w_bit_m1;
  logic [W_Gap-1:0]     r_gap;
  logic                 r_spi_clk;
  logic                 r_cs_n;
  logic                 r_mosi;
  logic                 r_last;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_done0;
  logic                 r_done1;
  logic                 w_grant;
  logic                 w_winner;
  logic                 w_sample_bit;
  logic [W_Data-1:0]    w_tx_sel;

`ifdef SPI_LOOPBACK_EN
  assign w_sample_bit = r_mosi;
`else
  assign w_sample_bit = bus.miso;
`endif

  assign w_bit_m1 = r_bit - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_grant     = 1'b1;
          // On a tie the requester that did not win last time goes next
          w_winner    = (bus.req0 && bus.req1) ? ~r_last_gnt : bus.req1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (!r_spi_clk && r_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_tx_sel = w_winner ? bus.tx1 : bus.tx0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_spi_clk  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_last     <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt0     <= ~w_winner;
            r_gnt1     <= w_winner;
            r_last_gnt <= w_winner;
            r_tx       <= w_tx_sel;
            r_rx       <= '0;
            r_cs_n     <= 1'b0;
            r_mosi     <= w_tx_sel[W_Data-1];
            r_bit      <= W_Counter'(W_Data - 1);
            r_last     <= 1'b0;
          end
        end
        S_SETUP: r_spi_clk <= 1'b1;
        S_SHIFT: begin
          if (r_spi_clk) begin
            r_rx[r_bit] <= w_sample_bit;
            r_spi_clk   <= 1'b0;
            if (r_bit == '0) begin
              r_last <= 1'b1;
            end else begin
              r_bit  <= w_bit_m1;
              r_mosi <= r_tx[w_bit_m1];
            end
          end else if (!r_last) begin
            r_spi_clk <= 1'b1;
          end
          // After the final falling edge spi_clk stays low for one cycle before DONE
        end
        S_DONE: begin
          r_rx_data <= r_rx;
          r_done0   <= ~r_last_gnt;
          r_done1   <= r_last_gnt;
          r_cs_n    <= 1'b1;
          r_mosi    <= 1'b0;
          r_gap     <= W_Gap'(Gap_Cycles - 1);
        end
        S_GAP: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.done0    = r_done0;
  assign bus.done1    = r_done1;
  assign bus.rx_data  = r_rx_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.spi_clk  = r_spi_clk;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.mosi     = r_mosi;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - directed bench for spi_xfer_arbiter with a mode-0 slave model
module tb_spi_xfer_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if #(.W_Data(32)) bus ();

  spi_xfer_arbiter #(
    .W_Data(32),
    .W_Counter(5),
    .Gap_Cycles(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int gnt0_cnt = 0;
  int gnt1_cnt = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;
  int excl_err = 0;
  int rise_cnt = 0;

  logic [31:0] slave_word = 32'h1234_5678;
  logic        slave_zero = 1'b0;
  logic [4:0]  k = 5'd31;
  logic [31:0] mosi_cap = '0;

  assign bus.miso = slave_zero ? 1'b0 : slave_word[k];

  // Mode-0 slave: presents the next bit after each falling spi_clk
  always @(negedge bus.spi_clk or posedge bus.spi_cs_n) begin
    if (bus.spi_cs_n) k = 5'd31;
    else k = k - 5'd1;
  end

  always @(posedge bus.spi_clk) begin
    mosi_cap = {mosi_cap[30:0], bus.mosi};
    rise_cnt = rise_cnt + 1;
  end

  always @(negedge clk) begin
    if (bus.gnt0) gnt0_cnt = gnt0_cnt + 1;
    if (bus.gnt1) gnt1_cnt = gnt1_cnt + 1;
    if (bus.done0) done0_cnt = done0_cnt + 1;
    if (bus.done1) done1_cnt = done1_cnt + 1;
    if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1) ||
        ((bus.gnt0 || bus.gnt1) && (bus.done0 || bus.done1)))
      excl_err = excl_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_rx(input logic [31:0] tx);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return slave_zero ? 32'h0 : slave_word;
`endif
  endfunction

  // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, other any gnt; cyc=-1 on timeout
  task automatic wait_pulse(input int sel, input int budget, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < budget) begin
      @(negedge clk);
      cyc = cyc + 1;
      case (sel)
        0: hit = bus.gnt0;
        1: hit = bus.gnt1;
        2: hit = bus.done0;
        3: hit = bus.done1;
        default: hit = bus.gnt0 | bus.gnt1;
      endcase
    end
    if (!hit) cyc = -1;
  endtask

  initial begin
    int c;
    int low;
    int r0;
    int g1;
    int d0;
    int d1;

    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.tx0  = '0;
    bus.tx1  = '0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cs_n", bus.spi_cs_n, 1);
    check("rst_spi_clk", bus.spi_clk, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_mosi", bus.mosi, 0);
    repeat (20) @(negedge clk);
    check("idle_no_gnt", 32'(gnt0_cnt + gnt1_cnt), 0);
    check("idle_no_done", 32'(done0_cnt + done1_cnt), 0);

    // Single transfer from requester 0
    bus.req0 = 1'b1;
    bus.tx0  = 32'hA5C3_0F01;
    r0 = rise_cnt;
    wait_pulse(0, 5, c);
    check("t2_req_to_gnt0", 32'(c), 1);
    bus.req0 = 1'b0;
    bus.tx0  = 32'hFFFF_FFFF;
    c = 0;
    low = 0;
    while (!bus.done0 && c < 100) begin
      if (!bus.spi_cs_n) low = low + 1;
      @(negedge clk);
      c = c + 1;
      if (c == 1) check("t2_gnt0_width", bus.gnt0, 0);
    end
    check("t2_gnt_to_done0", 32'(c), 66);
    check("t2_cs_low_cycles", 32'(low), 66);
    check("t2_rx_data", bus.rx_data, exp_rx(32'hA5C3_0F01));
    check("t2_mosi_word", mosi_cap, 32'hA5C3_0F01);
    check("t2_spi_rises", 32'(rise_cnt - r0), 32);
    check("t2_cs_high_at_done", bus.spi_cs_n, 1);
    @(negedge clk);
    check("t2_done0_width", bus.done0, 0);
    repeat (5) @(negedge clk);

    // Contention from reset
    rst = 1'b1;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.tx0  = 32'h1111_2222;
    bus.tx1  = 32'h3333_4444;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_pulse(4, 5, c);
    check("t3_first_lat", 32'(c), 1);
    check("t3_first_is_gnt0", bus.gnt0, 1);
    wait_pulse(2, 100, c);
    check("t3_done0_lat", 32'(c), 66);
    wait_pulse(4, 10, c);
    check("t3_done_to_gnt", 32'(c), 3);
    check("t3_second_is_gnt1", bus.gnt1, 1);
    wait_pulse(3, 100, c);
    check("t3_done1_lat", 32'(c), 66);
    check("t3_mosi_word1", mosi_cap, 32'h3333_4444);
    wait_pulse(4, 10, c);
    check("t3_done_to_gnt_b", 32'(c), 3);
    check("t3_third_is_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_pulse(2, 100, c);
    check("t3_done0_b_lat", 32'(c), 66);
    repeat (5) @(negedge clk);

    // Reset mid-transfer
    bus.req0 = 1'b1;
    bus.tx0  = 32'hC0FF_EE00;
    wait_pulse(0, 5, c);
    bus.req0 = 1'b0;
    repeat (20) @(negedge clk);
    check("t4_cs_low_pre", bus.spi_cs_n, 0);
    d0 = done0_cnt;
    rst = 1'b1;
    #1;
    check("t4_cs_n_async", bus.spi_cs_n, 1);
    check("t4_spi_clk_async", bus.spi_clk, 0);
    check("t4_busy_async", bus.busy, 0);
    check("t4_mosi_async", bus.mosi, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req1 = 1'b1;
    bus.tx1  = 32'h5A5A_1234;
    wait_pulse(1, 5, c);
    check("t4_gnt1_lat", 32'(c), 1);
    bus.req1 = 1'b0;
    wait_pulse(3, 100, c);
    check("t4_done1_lat", 32'(c), 66);
    check("t4_rx_data", bus.rx_data, exp_rx(32'h5A5A_1234));
    check("t4_no_aborted_done", 32'(done0_cnt - d0), 0);
    repeat (5) @(negedge clk);

    // Request withdrawal while busy
    g1 = gnt1_cnt;
    d1 = done1_cnt;
    bus.req0 = 1'b1;
    bus.tx0  = 32'h0000_00FF;
    wait_pulse(0, 5, c);
    bus.req0 = 1'b0;
    repeat (5) @(negedge clk);
    bus.req1 = 1'b1;
    @(negedge clk);
    bus.req1 = 1'b0;
    wait_pulse(2, 100, c);
    check("t5_done0_seen", bus.done0, 1);
    repeat (20) @(negedge clk);
    check("t5_no_gnt1", 32'(gnt1_cnt - g1), 0);
    check("t5_no_done1", 32'(done1_cnt - d1), 0);

    // miso tied low: zero word, or the transmitted word in loopback builds
    slave_zero = 1'b1;
    bus.req1 = 1'b1;
    bus.tx1  = 32'hDEAD_BEEF;
    wait_pulse(1, 5, c);
    check("t6_gnt1_lat", 32'(c), 1);
    bus.req1 = 1'b0;
    wait_pulse(3, 100, c);
    check("t6_done1_lat", 32'(c), 66);
    check("t6_rx_data", bus.rx_data, exp_rx(32'hDEAD_BEEF));
    slave_zero = 1'b0;
    repeat (5) @(negedge clk);

    check("excl_pulses", 32'(excl_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
